// File: rtl/sys_pkg.sv
// Shared definitions for the SYS_CTRL result path: arbiter states,
// grant encoding and default data widths.
package sys_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ALU_WIDTH  = 16;

  localparam logic GNT_RF  = 1'b0;
  localparam logic GNT_ALU = 1'b1;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    SEND_RF     = 2'd1,
    SEND_ALU_LO = 2'd2,
    SEND_ALU_HI = 2'd3
  } arb_state_e;

endpackage

// File: rtl/result_hold_reg.sv
// One-entry holding buffer for a single-cycle result pulse. A load on the
// same edge the entry is freed is accepted; a load into a busy entry is dropped.
module result_hold_reg
  import sys_pkg::*;
#(
  parameter int WIDTH = DEF_DATA_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             free_i,
  output logic             pend_o,
  output logic [WIDTH-1:0] data_o,
  output logic             ovf_o
);

  logic             pend_q, pend_d;
  logic [WIDTH-1:0] data_q, data_d;

  // next-state of the entry; ovf_o is a one-cycle drop indication
  always_comb begin
    pend_d = pend_q;
    data_d = data_q;
    ovf_o  = 1'b0;
    if (load_i) begin
      if (!pend_q || free_i) begin
        pend_d = 1'b1;
        data_d = data_i;
      end else begin
        ovf_o = 1'b1;
      end
    end else if (free_i) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q;
    end
  end

  // entry registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q <= 1'b0;
      data_q <= {WIDTH{1'b0}};
    end else begin
      pend_q <= pend_d;
      data_q <= data_d;
    end
  end

  assign pend_o = pend_q;
  assign data_o = data_q;

endmodule

// File: rtl/tx_result_arbiter.sv
// Round-robin sharing of the TX async FIFO write port between RegFile read
// responses (one byte) and ALU results (two bytes, LSB first).
module tx_result_arbiter
  import sys_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ALU_WIDTH  = DEF_ALU_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RF_RD_DATA,
  input  logic                  RF_RD_VLD,
  input  logic [ALU_WIDTH-1:0]  ALU_OUT,
  input  logic                  ALU_OUT_VLD,
  input  logic                  FIFO_FULL,
  input  logic                  CLR_OVF,
  output logic [DATA_WIDTH-1:0] WR_DATA,
  output logic                  W_INC,
  output logic                  BUSY,
  output logic                  OVF
);

  arb_state_e state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic       ovf_q, ovf_d;

  logic                  rf_pend_s, alu_pend_s;
  logic                  rf_ovf_s, alu_ovf_s;
  logic                  rf_free_s, alu_free_s;
  logic [DATA_WIDTH-1:0] rf_buf_s;
  logic [ALU_WIDTH-1:0]  alu_buf_s;

  // an entry is released on the edge its last byte enters the FIFO
  assign rf_free_s  = (state_q == SEND_RF) && !FIFO_FULL;
  assign alu_free_s = (state_q == SEND_ALU_HI) && !FIFO_FULL;

  result_hold_reg #(.WIDTH(DATA_WIDTH)) u_rf_hold (
    .clk_i  (CLK),
    .rst_i  (RST),
    .load_i (RF_RD_VLD),
    .data_i (RF_RD_DATA),
    .free_i (rf_free_s),
    .pend_o (rf_pend_s),
    .data_o (rf_buf_s),
    .ovf_o  (rf_ovf_s)
  );

  result_hold_reg #(.WIDTH(ALU_WIDTH)) u_alu_hold (
    .clk_i  (CLK),
    .rst_i  (RST),
    .load_i (ALU_OUT_VLD),
    .data_i (ALU_OUT),
    .free_i (alu_free_s),
    .pend_o (alu_pend_s),
    .data_o (alu_buf_s),
    .ovf_o  (alu_ovf_s)
  );

  // grant decision and byte sequencing; states hold while the FIFO is full
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (rf_pend_s && alu_pend_s) begin
          if (last_grant_q == GNT_ALU) begin
            state_d      = SEND_RF;
            last_grant_d = GNT_RF;
          end else begin
            state_d      = SEND_ALU_LO;
            last_grant_d = GNT_ALU;
          end
        end else if (rf_pend_s) begin
          state_d      = SEND_RF;
          last_grant_d = GNT_RF;
        end else if (alu_pend_s) begin
          state_d      = SEND_ALU_LO;
          last_grant_d = GNT_ALU;
        end else begin
          state_d = IDLE;
        end
      end
      SEND_RF: begin
        if (!FIFO_FULL) begin
          state_d = IDLE;
        end else begin
          state_d = SEND_RF;
        end
      end
      SEND_ALU_LO: begin
        if (!FIFO_FULL) begin
          state_d = SEND_ALU_HI;
        end else begin
          state_d = SEND_ALU_LO;
        end
      end
      SEND_ALU_HI: begin
        if (!FIFO_FULL) begin
          state_d = IDLE;
        end else begin
          state_d = SEND_ALU_HI;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // a fresh overflow wins over a simultaneous clear
  always_comb begin
    ovf_d = (ovf_q && !CLR_OVF) || rf_ovf_s || alu_ovf_s;
  end

  // control registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_ALU;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      ovf_q        <= ovf_d;
    end
  end

  // write port decoded from the registered state
  always_comb begin
    W_INC = (state_q != IDLE) && !FIFO_FULL;
    case (state_q)
      SEND_RF:     WR_DATA = rf_buf_s;
      SEND_ALU_LO: WR_DATA = alu_buf_s[DATA_WIDTH-1:0];
      SEND_ALU_HI: WR_DATA = alu_buf_s[ALU_WIDTH-1:DATA_WIDTH];
      default:     WR_DATA = {DATA_WIDTH{1'b0}};
    endcase
  end

  assign BUSY = rf_pend_s || alu_pend_s || (state_q != IDLE);
  assign OVF  = ovf_q;

endmodule
